// File: rtl/sample_spi_readout_pkg.sv
// sample_spi_readout_pkg: FSM states, frame header layout and sizing helpers for the SPI readout.
package sample_spi_readout_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;
   localparam int SEQ_W = 3;
   localparam int HDR_W = SEQ_W + 1;
   function automatic int max2(int a, int b);
      return a > b ? a : b;
   endfunction
endpackage

// File: rtl/sample_spi_readout_if.sv
// sample_spi_readout_if: filter-side sample strobe plus SPI pins and status of the readout stage.
interface sample_spi_readout_if #(
   parameter int DATA_W     = 12,
   parameter int FIFO_DEPTH = 4
);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
   logic [DATA_W-1:0] sample_in;
   logic              sample_valid;
   logic              sclk;
   logic              cs_n;
   logic              sdo;
   logic [LVL_W-1:0]  fifo_level;
   logic              overflow;
   logic              busy;
   modport master (output sample_in, sample_valid, input sclk, cs_n, sdo, fifo_level, overflow, busy);
   modport slave  (input sample_in, sample_valid, output sclk, cs_n, sdo, fifo_level, overflow, busy);
endinterface

// File: rtl/sample_spi_readout_fifo.sv
// sample_spi_readout_fifo: synchronous sample FIFO with occupancy count; callers never push when full unless popping.
module sample_spi_readout_fifo #(
   parameter int DATA_W = 12,
   parameter int DEPTH  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic                    pop,
   input  logic [DATA_W-1:0]       din,
   output logic [DATA_W-1:0]       dout,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  level
);
   localparam int AW = $clog2(DEPTH);
   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         level <= level + (AW+1)'(push) - (AW+1)'(pop);
      end
   end
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= din;
   assign dout  = mem[rd_ptr];
   assign full  = level == (AW+1)'(DEPTH);
   assign empty = level == '0;
endmodule

// File: rtl/sample_spi_readout.sv
// sample_spi_readout: buffers decimated samples and ships each as a {drop, seq, sample} SPI mode-0 frame.
module sample_spi_readout
   import sample_spi_readout_pkg::*;
#(
   parameter int DATA_W     = 12,
   parameter int FIFO_DEPTH = 4,
   parameter int CLK_DIV    = 2,
   parameter int GAP_CYC    = 2
) (
   input logic                 clk,
   input logic                 rst,
   sample_spi_readout_if.slave bus
);
   localparam int FRAME_W = DATA_W + HDR_W;
   localparam int BIT_W   = $clog2(FRAME_W);
   localparam int CNT_W   = $clog2(max2(CLK_DIV, GAP_CYC)) + 1;
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [BIT_W-1:0]   bit_cnt;
   logic [FRAME_W-1:0] frame;
   logic [SEQ_W-1:0]   seq;
   logic               drop_pend;
   logic [DATA_W-1:0]  head;
   logic               full;
   logic               empty;
   logic               pop;
   logic               push;
   logic               tick;
   logic               last;
   // A pop in LOAD frees a slot, so a coincident write into a full FIFO is still accepted.
   assign pop  = state == LOAD;
   assign push = bus.sample_valid & (~full | pop);
   assign tick = state == SHIFT && cnt == DIV_LAST;
   assign last = tick & bus.sclk & (bit_cnt == '0);
   sample_spi_readout_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) fifo (
      .clk(clk),
      .rst(rst),
      .push(push),
      .pop(pop),
      .din(bus.sample_in),
      .dout(head),
      .full(full),
      .empty(empty),
      .level(bus.fifo_level)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  state_nxt = empty ? IDLE : LOAD;
         LOAD:  state_nxt = SHIFT;
         SHIFT: state_nxt = last ? GAP : SHIFT;
         GAP:   state_nxt = cnt == GAP_LAST ? IDLE : GAP;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.sclk     <= 1'b0;
         bus.cs_n     <= 1'b1;
         bus.sdo      <= 1'b0;
         bus.overflow <= 1'b0;
         bus.busy     <= 1'b0;
         cnt          <= '0;
         bit_cnt      <= '0;
         frame        <= '0;
         seq          <= '0;
         drop_pend    <= 1'b0;
      end else begin
         bus.busy <= state_nxt != IDLE;
         case (state)
            LOAD: begin
               frame     <= {drop_pend, seq, head};
               bus.sdo   <= drop_pend;
               bus.cs_n  <= 1'b0;
               bus.sclk  <= 1'b0;
               cnt       <= '0;
               bit_cnt   <= BIT_W'(FRAME_W - 1);
               drop_pend <= 1'b0;
            end
            SHIFT: begin
               cnt <= tick ? '0 : cnt + CNT_W'(1);
               if (tick) bus.sclk <= ~bus.sclk;
               // The edge that lowers sclk presents the next bit, or closes the frame after the last one.
               if (last) begin
                  bus.cs_n <= 1'b1;
                  bus.sdo  <= 1'b0;
                  seq      <= seq + SEQ_W'(1);
               end else if (tick & bus.sclk) begin
                  bus.sdo <= frame[FRAME_W-2];
                  frame   <= frame << 1;
                  bit_cnt <= bit_cnt - BIT_W'(1);
               end
            end
            GAP: cnt <= cnt + CNT_W'(1);
            default: ;
         endcase
         if (bus.sample_valid & full & ~pop) begin
            drop_pend    <= 1'b1;
            bus.overflow <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_sample_spi_readout.sv
// tb_sample_spi_readout: directed checks of latency, framing, sequence wrap, overflow, collision and throughput.
module tb_sample_spi_readout;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          checks = 0;
   int          failures = 0;
   logic [15:0] frames[$];
   int          lows[$];
   int          nbits[$];
   logic [15:0] acc = '0;
   int          low_cnt = 0;
   int          bit_n = 0;
   logic        sclk_q = 1'b0;
   logic        cs_q = 1'b1;
   logic [15:0] exp_q[$];
   int          max_lvl;
   int          c;
   sample_spi_readout_if #(.DATA_W(12), .FIFO_DEPTH(4)) bus ();
   sample_spi_readout #(.DATA_W(12), .FIFO_DEPTH(4), .CLK_DIV(2), .GAP_CYC(2)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   always #5 clk = ~clk;
   // Slave-side capture: sdo taken when sclk is first seen high, frame closed when cs_n rises.
   always @(negedge clk) begin
      if (rst) begin
         acc = '0;
         low_cnt = 0;
         bit_n = 0;
      end else begin
         if (!bus.cs_n) low_cnt++;
         if (bus.sclk && !sclk_q && !bus.cs_n) begin
            acc = {acc[14:0], bus.sdo};
            bit_n++;
         end
         if (bus.cs_n && !cs_q) begin
            frames.push_back(acc);
            lows.push_back(low_cnt);
            nbits.push_back(bit_n);
            acc = '0;
            low_cnt = 0;
            bit_n = 0;
         end
      end
      sclk_q = bus.sclk;
      cs_q = bus.cs_n;
   end
   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic push(logic [11:0] v);
      @(negedge clk);
      bus.sample_in = v;
      bus.sample_valid = 1'b1;
      @(negedge clk);
      bus.sample_valid = 1'b0;
   endtask
   task automatic wait_frames(string tag, int n, int budget);
      int k = 0;
      while (frames.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(tag, frames.size(), n);
   endtask
   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      frames.delete();
      lows.delete();
      nbits.delete();
      @(negedge clk);
      rst = 1'b0;
   endtask
   initial begin
      bus.sample_in = '0;
      bus.sample_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_cs_n", bus.cs_n, 1);
      check("rst_sclk", bus.sclk, 0);
      check("rst_sdo", bus.sdo, 0);
      check("rst_level", bus.fifo_level, 0);
      check("rst_overflow", bus.overflow, 0);
      check("rst_busy", bus.busy, 0);
      rst = 1'b0;
      // single frame and two-edge latency
      push(12'hA5C);
      check("lat_level1", bus.fifo_level, 1);
      check("lat_busy0", bus.busy, 0);
      check("lat_cs1", bus.cs_n, 1);
      @(negedge clk);
      check("lat_busy1", bus.busy, 1);
      check("lat_cs2", bus.cs_n, 1);
      @(negedge clk);
      check("lat_cs_low", bus.cs_n, 0);
      check("lat_level0", bus.fifo_level, 0);
      wait_frames("t2_count", 1, 200);
      check("t2_frame", frames[0], 16'h0A5C);
      check("t2_bits", nbits[0], 16);
      check("t2_cs_low", lows[0], 64);
      push(12'h123);
      wait_frames("t2_count2", 2, 200);
      check("t2_frame_seq1", frames[1], 16'h1123);
      // async reset mid-frame
      push(12'h777);
      repeat (20) @(negedge clk);
      check("t1_mid_shift", bus.cs_n, 0);
      #2 rst = 1'b1;
      #1;
      check("t1_async_cs", bus.cs_n, 1);
      check("t1_async_sclk", bus.sclk, 0);
      @(negedge clk);
      check("t1_cs_n", bus.cs_n, 1);
      check("t1_sclk", bus.sclk, 0);
      check("t1_sdo", bus.sdo, 0);
      check("t1_level", bus.fifo_level, 0);
      check("t1_overflow", bus.overflow, 0);
      check("t1_busy", bus.busy, 0);
      frames.delete();
      lows.delete();
      nbits.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (100) @(negedge clk);
      check("t1_abandoned", frames.size(), 0);
      // sequence wrap, seq restarted by the reset above
      for (int i = 0; i < 9; i++) begin
         push(12'h100 + 12'(i));
         wait_frames("t3_count", i + 1, 200);
         check("t3_frame", frames[i], {1'b0, 3'(i), 12'h100 + 12'(i)});
      end
      // overflow with six back-to-back samples
      do_reset();
      for (int k = 1; k <= 6; k++) begin
         bus.sample_in = 12'(k);
         bus.sample_valid = 1'b1;
         @(negedge clk);
      end
      bus.sample_valid = 1'b0;
      check("t4_level", bus.fifo_level, 4);
      check("t4_overflow", bus.overflow, 1);
      exp_q = '{16'h0001, 16'h9002, 16'h2003, 16'h3004, 16'h4005};
      wait_frames("t4_count", 5, 700);
      for (int i = 0; i < 5; i++) check("t4_frame", frames[i], exp_q[i]);
      repeat (100) @(negedge clk);
      check("t4_no_extra", frames.size(), 5);
      check("t4_sticky", bus.overflow, 1);
      // write colliding with the pop of a full FIFO
      do_reset();
      for (int k = 1; k <= 5; k++) begin
         bus.sample_in = 12'(8'h11 * k);
         bus.sample_valid = 1'b1;
         @(negedge clk);
      end
      bus.sample_valid = 1'b0;
      check("t5_full", bus.fifo_level, 4);
      c = 0;
      while (bus.busy !== 1'b0 && c < 300) begin
         @(negedge clk);
         c++;
      end
      check("t5_idle", bus.busy, 0);
      c = 0;
      while (bus.busy !== 1'b1 && c < 20) begin
         @(negedge clk);
         c++;
      end
      check("t5_load", bus.busy, 1);
      bus.sample_in = 12'h0EE;
      bus.sample_valid = 1'b1;
      @(negedge clk);
      bus.sample_valid = 1'b0;
      check("t5_level", bus.fifo_level, 4);
      check("t5_overflow", bus.overflow, 0);
      check("t5_cs_low", bus.cs_n, 0);
      exp_q = '{16'h0011, 16'h1022, 16'h2033, 16'h3044, 16'h4055, 16'h50EE};
      wait_frames("t5_count", 6, 800);
      for (int i = 0; i < 6; i++) check("t5_frame", frames[i], exp_q[i]);
      // sustained throughput at one sample per 70 cycles
      do_reset();
      exp_q.delete();
      max_lvl = 0;
      for (int i = 0; i < 100; i++) begin
         exp_q.push_back({1'b0, 3'(i), 12'(i * 37 + 5)});
         push(12'(i * 37 + 5));
         repeat (68) begin
            @(negedge clk);
            if (int'(bus.fifo_level) > max_lvl) max_lvl = int'(bus.fifo_level);
         end
      end
      wait_frames("t6_count", 100, 300);
      for (int i = 0; i < 100; i++) check("t6_frame", frames[i], exp_q[i]);
      check("t6_max_level", max_lvl <= 1, 1);
      check("t6_overflow", bus.overflow, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
